// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Package : ahb_pkg
// Shared AHB-Lite encodings and default-slave state type.
// Rev     : 1.0
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam int NS_MAX = 4;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } def_state_t;

    // Isolate the lowest set bit: implements lowest-index-wins arbitration.
    function automatic logic [NS_MAX-1:0] lowest_one(input logic [NS_MAX-1:0] v);
        return v & (-v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_mux_if.sv
`default_nettype none
// ============================================================================
// Interface : ahb_slave_mux_if
// Master-side and slave-side AHB-Lite signals around the slave multiplexer.
// Rev       : 1.0
// ============================================================================
interface ahb_slave_mux_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    logic        HSEL_S0;
    logic        HSEL_S1;
    logic        HSEL_S2;
    logic        HSEL_S3;
    logic        HREADYOUT_S0;
    logic        HREADYOUT_S1;
    logic        HREADYOUT_S2;
    logic        HREADYOUT_S3;
    logic [1:0]  HRESP_S0;
    logic [1:0]  HRESP_S1;
    logic [1:0]  HRESP_S2;
    logic [1:0]  HRESP_S3;
    logic [31:0] HRDATA_S0;
    logic [31:0] HRDATA_S1;
    logic [31:0] HRDATA_S2;
    logic [31:0] HRDATA_S3;

    // slave: the multiplexer itself; master: the bus master plus the slaves around it
    modport slave (
        input  HADDR, HTRANS,
        input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
        input  HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3,
        input  HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
        output HREADY, HRESP, HRDATA,
        output HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3
    );

    modport master (
        output HADDR, HTRANS,
        output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
        output HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3,
        output HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
        input  HREADY, HRESP, HRDATA,
        input  HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3
    );

endinterface
`default_nettype wire

// File: rtl/ahb_default_slave.sv
`default_nettype none
// ============================================================================
// Module : ahb_default_slave
// Answers active transfers to unmapped space with a two-cycle ERROR response.
// Rev    : 1.0
// ============================================================================
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       sel,
    input  logic       trans_active,
    input  logic       hready,
    output logic       HREADYOUT,
    output logic [1:0] HRESP
);

    def_state_t r_state;
    logic       w_req;

    assign w_req = sel & trans_active & hready;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= DS_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
        end else begin
            case (r_state)
                DS_IDLE: begin
                    if (w_req) begin
                        r_state   <= DS_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    r_state   <= DS_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    // ERR2 completes the data phase, so a new unmapped request can chain directly
                    if (w_req) begin
                        r_state   <= DS_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= HRESP_ERROR;
                    end else begin
                        r_state   <= DS_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
                default: begin
                    r_state   <= DS_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_slave_mux.sv
`default_nettype none
// ============================================================================
// Module : ahb_slave_mux
// AHB-Lite address decoder and data-phase response mux for up to four slaves.
// Rev    : 1.0
// ============================================================================
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int          NS      = 4,
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S1_BASE = 32'h2000_0000,
    parameter logic [31:0] S2_BASE = 32'h4000_0000,
    parameter logic [31:0] S3_BASE = 32'h6000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S2_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S3_MASK = 32'hFFFF_0000
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahb_slave_mux_if.slave bus
);

    localparam logic [NS_MAX-1:0][31:0] c_base = {S3_BASE, S2_BASE, S1_BASE, S0_BASE};
    localparam logic [NS_MAX-1:0][31:0] c_mask = {S3_MASK, S2_MASK, S1_MASK, S0_MASK};

    logic [NS_MAX-1:0]       w_match;
    logic [NS_MAX-1:0]       w_win;
    logic                    w_none;
    logic                    w_trans_active;
    logic [NS_MAX:0]         r_dsel;

    logic [NS_MAX-1:0]       w_s_ready;
    logic [NS_MAX-1:0][1:0]  w_s_resp;
    logic [NS_MAX-1:0][31:0] w_s_rdata;

    logic                    w_def_ready;
    logic [1:0]              w_def_resp;
    logic                    w_hready;
    logic [1:0]              w_hresp;
    logic [31:0]             w_hrdata;

    genvar n;
    generate
        for (n = 0; n < NS_MAX; n++) begin : g_match
            assign w_match[n] = (n < NS) && ((bus.HADDR & c_mask[n]) == c_base[n]);
        end
    endgenerate

    assign w_win          = lowest_one(w_match);
    assign w_none         = ~|w_match;
    assign w_trans_active = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);

    assign bus.HSEL_S0 = w_win[0];
    assign bus.HSEL_S1 = w_win[1];
    assign bus.HSEL_S2 = w_win[2];
    assign bus.HSEL_S3 = w_win[3];

    assign w_s_ready = {bus.HREADYOUT_S3, bus.HREADYOUT_S2, bus.HREADYOUT_S1, bus.HREADYOUT_S0};
    assign w_s_resp  = {bus.HRESP_S3, bus.HRESP_S2, bus.HRESP_S1, bus.HRESP_S0};
    assign w_s_rdata = {bus.HRDATA_S3, bus.HRDATA_S2, bus.HRDATA_S1, bus.HRDATA_S0};

    // Bit NS_MAX of the data-phase select is the internal default slave.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dsel <= {1'b1, {NS_MAX{1'b0}}};
        end else if (w_hready) begin
            r_dsel <= {w_none, w_win};
        end
    end

    ahb_default_slave u_default_slave (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .sel          (w_none),
        .trans_active (w_trans_active),
        .hready       (w_hready),
        .HREADYOUT    (w_def_ready),
        .HRESP        (w_def_resp)
    );

    always_comb begin
        w_hready = w_def_ready;
        w_hresp  = w_def_resp;
        w_hrdata = 32'h0;
        for (int i = 0; i < NS_MAX; i++) begin
            if (r_dsel[i]) begin
                w_hready = w_s_ready[i];
                w_hresp  = w_s_resp[i];
                w_hrdata = w_s_rdata[i];
            end
        end
    end

    assign bus.HREADY = w_hready;
    assign bus.HRESP  = w_hresp;
    assign bus.HRDATA = w_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_ahb_slave_mux
// Three mux configurations (default map, S0 matching everything, NS = 2)
// driven in lockstep and compared against a transaction-level reference.
// Rev    : 1.0
// ============================================================================
module tb_ahb_slave_mux;

    localparam int ND = 3;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b1;
    always #5 HCLK = ~HCLK;

    logic [31:0]       haddr  = 32'h0;
    logic [1:0]        htrans = 2'b00;
    logic [3:0]        s_rdy  = 4'hF;
    logic [3:0][1:0]   s_resp = '0;
    logic [3:0][31:0]  s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};

    wire [ND-1:0]        o_ready;
    wire [ND-1:0][1:0]   o_resp;
    wire [ND-1:0][31:0]  o_rdata;
    wire [ND-1:0][3:0]   o_hsel;

    genvar k;
    generate
        for (k = 0; k < ND; k++) begin : g_dut
            ahb_slave_mux_if bus ();
            assign bus.HADDR        = haddr;
            assign bus.HTRANS       = htrans;
            assign bus.HREADYOUT_S0 = s_rdy[0];
            assign bus.HREADYOUT_S1 = s_rdy[1];
            assign bus.HREADYOUT_S2 = s_rdy[2];
            assign bus.HREADYOUT_S3 = s_rdy[3];
            assign bus.HRESP_S0     = s_resp[0];
            assign bus.HRESP_S1     = s_resp[1];
            assign bus.HRESP_S2     = s_resp[2];
            assign bus.HRESP_S3     = s_resp[3];
            assign bus.HRDATA_S0    = s_rdata[0];
            assign bus.HRDATA_S1    = s_rdata[1];
            assign bus.HRDATA_S2    = s_rdata[2];
            assign bus.HRDATA_S3    = s_rdata[3];
            assign o_ready[k] = bus.HREADY;
            assign o_resp[k]  = bus.HRESP;
            assign o_rdata[k] = bus.HRDATA;
            assign o_hsel[k]  = {bus.HSEL_S3, bus.HSEL_S2, bus.HSEL_S1, bus.HSEL_S0};

            ahb_slave_mux #(
                .NS      ((k == 2) ? 2 : 4),
                .S0_MASK ((k == 1) ? 32'h0000_0000 : 32'hFFFF_0000)
            ) u_dut (
                .HCLK    (HCLK),
                .HRESETn (HRESETn),
                .bus     (bus)
            );
        end
    endgenerate

    // Reference: who owns the data phase (0..3 slave, 4 default) and how many
    // error cycles remain (2 = first error cycle, 1 = final error cycle).
    int m_owner [ND];
    int m_err   [ND];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic int decode(input int dut, input logic [31:0] a);
        int          ns;
        logic [31:0] m;
        logic [31:0] b;
        ns = (dut == 2) ? 2 : 4;
        for (int p = 0; p < ns; p++) begin
            m = (dut == 1 && p == 0) ? 32'h0 : 32'hFFFF_0000;
            b = 32'(p) * 32'h2000_0000;
            if ((a & m) == b) return p;
        end
        return 4;
    endfunction

    function automatic logic exp_ready(input int dut);
        if (m_owner[dut] < 4) return s_rdy[m_owner[dut]];
        return (m_err[dut] != 2);
    endfunction

    function automatic logic [1:0] exp_resp(input int dut);
        if (m_owner[dut] < 4) return s_resp[m_owner[dut]];
        return (m_err[dut] != 0) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [31:0] exp_rdata(input int dut);
        if (m_owner[dut] < 4) return s_rdata[m_owner[dut]];
        return 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string phase);
        int d;
        for (int i = 0; i < ND; i++) begin
            d = decode(i, haddr);
            check($sformatf("%s dut%0d hsel", phase, i), 32'(o_hsel[i]), (d < 4) ? (32'd1 << d) : 32'd0);
            check($sformatf("%s dut%0d hready", phase, i), 32'(o_ready[i]), 32'(exp_ready(i)));
            check($sformatf("%s dut%0d hresp", phase, i), 32'(o_resp[i]), 32'(exp_resp(i)));
            check($sformatf("%s dut%0d hrdata", phase, i), o_rdata[i], exp_rdata(i));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_owner[i] = 4;
            m_err[i]   = 0;
        end
    endtask

    task automatic advance();
        int d;
        for (int i = 0; i < ND; i++) begin
            if (!HRESETn) begin
                m_owner[i] = 4;
                m_err[i]   = 0;
            end else if (m_err[i] == 2) begin
                m_err[i] = 1;
            end else if (exp_ready(i)) begin
                d          = decode(i, haddr);
                m_owner[i] = d;
                m_err[i]   = (d == 4 && htrans[1]) ? 2 : 0;
            end
        end
    endtask

    task automatic step(input string phase, input logic [31:0] a, input logic [1:0] t);
        haddr  = a;
        htrans = t;
        @(negedge HCLK);
        check_all(phase);
        advance();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        model_reset();
        #2 HRESETn = 1'b0;
        @(posedge HCLK);
        #1;

        step("reset0", 32'h2000_0010, 2'b00);
        step("reset1", 32'h2000_0010, 2'b00);
        HRESETn = 1'b1;
        step("post_reset", 32'h2000_0010, 2'b00);

        // Mapped read with two wait states; an unmapped NONSEQ waits behind it.
        s_rdata[0] = 32'hDEAD_BEEF;
        step("rd_addr", 32'h0000_0004, 2'b10);
        s_rdy[0] = 1'b0;
        step("rd_wait1", 32'hF000_0000, 2'b10);
        step("rd_wait2", 32'hF000_0000, 2'b10);
        s_rdy[0] = 1'b1;
        step("rd_done", 32'h0000_0000, 2'b00);
        step("rd_tail", 32'h0000_0000, 2'b00);

        // Pipelined S0 write then S2 read with no bubble.
        s_rdata[2] = 32'hCAFE_0002;
        step("pipe_s0", 32'h0000_0010, 2'b10);
        step("pipe_s2", 32'h4000_0000, 2'b10);
        step("pipe_d2", 32'h0000_0000, 2'b00);
        step("pipe_end", 32'h0000_0000, 2'b00);

        // Unmapped NONSEQ, then IDLE to the same address.
        step("um_addr", 32'hF000_0000, 2'b10);
        step("um_err1", 32'h0000_0000, 2'b00);
        step("um_err2", 32'h0000_0000, 2'b00);
        step("um_idle", 32'hF000_0000, 2'b00);
        step("um_okay", 32'h0000_0000, 2'b00);

        // Back-to-back errors: second request accepted in ERR2.
        step("b2b_addr", 32'hF000_0000, 2'b10);
        step("b2b_err1a", 32'hF000_0000, 2'b10);
        step("b2b_err2a", 32'hF000_0000, 2'b11);
        step("b2b_err1b", 32'h0000_0000, 2'b00);
        step("b2b_err2b", 32'h0000_0000, 2'b00);
        step("b2b_idle", 32'h0000_0000, 2'b00);

        // Slave 3 window: mapped on the full config, unmapped when NS = 2.
        s_rdata[3] = 32'h6000_0003;
        step("s3_addr", 32'h6000_0000, 2'b10);
        step("s3_data", 32'h0000_0000, 2'b00);
        step("s3_err2", 32'h0000_0000, 2'b00);
        step("s3_end", 32'h0000_0000, 2'b00);

        // Asynchronous reset while in the first error cycle.
        step("rst_addr", 32'hF000_0000, 2'b10);
        HRESETn = 1'b0;
        model_reset();
        #1;
        check_all("rst_err1");
        step("rst_hold", 32'h0000_0000, 2'b00);
        HRESETn = 1'b1;
        step("rst_rel", 32'h0000_0000, 2'b00);

        // Randomized traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 4; p++) begin
                s_rdy[p]   = 1'($urandom_range(0, 3) != 0);
                s_resp[p]  = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
                s_rdata[p] = $urandom;
            end
            a = $urandom;
            r = $urandom_range(0, 6);
            if (r < 4)       a = (32'(r) << 29) | (a & 32'h0000_FFFF);
            else if (r == 4) a = 32'hF000_0000 | (a & 32'h0000_FFFF);
            step("rand", a, 2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_slave_mux.md
# ahb_slave_mux

AHB-Lite address decoder and slave-side multiplexer placed between the single system master and up to four AHB slaves, including the SRAM bridges that drive the on-chip SRAM macros. It decodes the address phase into one-hot HSEL outputs and registers the selection for the data phase. It steers the selected slave's HRDATA, HREADYOUT and HRESP back to the master. Accesses to unmapped space go to an internal default slave, which returns a two-cycle AHB ERROR response.

## Interface
- NS, 4: number of slave ports in use (1..4); ports at or above NS are never selected.
- S0_BASE, 32'h0000_0000: base address of slave 0; S1_BASE 32'h2000_0000, S2_BASE 32'h4000_0000, S3_BASE 32'h6000_0000.
- S0_MASK, 32'hFFFF_0000: address match mask of slave 0; S1..S3_MASK use the same default.
- Decode rule: port n matches when (HADDR & Sn_MASK) == Sn_BASE.

Ports:
- HCLK  in  1  system bus clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type.
- HREADY  out  1  muxed ready; goes to the master and is broadcast to all slaves as their HREADY.
- HRESP  out  2  muxed response; 2'b00 = OKAY, 2'b01 = ERROR.
- HRDATA  out  32  muxed read data.
- HSEL_S0..HSEL_S3  out  1 each  address-phase slave selects.
- HREADYOUT_S0..S3  in  1 each  slave ready outputs.
- HRESP_S0..S3  in  2 each  slave responses.
- HRDATA_S0..S3  in  32 each  slave read data.

## Operation
- Address decode is combinational from HADDR.
  - When several windows match, the lowest index wins.
  - HSEL_Sn is asserted only for the winning port with n < NS; it is independent of HTRANS.
  - The default slave is selected (dsel_def) when no port wins.
- Data-phase select register dsel (one-hot of 5: S0..S3 and DEF).
  - Loads the address-phase decode on the rising HCLK edge when HREADY = 1.
  - Holds while HREADY = 0.
- Output mux when dsel = Sn: HREADY = HREADYOUT_Sn, HRESP = HRESP_Sn, HRDATA = HRDATA_Sn.
- Output mux when dsel = DEF: the default slave drives HREADY and HRESP, and HRDATA = 32'h0.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 when HREADY = 1, no window matches, and HTRANS[1] = 1 (NONSEQ or SEQ).
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> ERR1 when HREADY = 1, no window matches, and HTRANS[1] = 1; otherwise ERR2 -> IDLE.
  - Outputs in IDLE: HREADY = 1, HRESP = 00.
  - Outputs in ERR1: HREADY = 0, HRESP = 01.
  - Outputs in ERR2: HREADY = 1, HRESP = 01.
- IDLE or BUSY transfers to unmapped space: zero-wait OKAY; the FSM stays in IDLE.
- Back-to-back transfers: a new address phase is accepted in the same cycle the previous data phase completes (HREADY = 1).
- The block itself never inserts a wait state for a mapped slave.

## Timing
- Reset values:
  - dsel = DEF and FSM = IDLE.
  - HREADY = 1, HRESP = 2'b00, HRDATA = 32'h0.
  - HSEL_Sn follow HADDR combinationally, so they are not gated by reset.
- Decode to HSEL: 0-cycle latency, combinational.
- Address phase to data-phase mux switch: 1 cycle, on the edge where HREADY = 1.
- Slave wait states: while HREADYOUT_Sn = 0, dsel is frozen and the address on HADDR is not latched.
- Unmapped NONSEQ: the data phase lasts exactly 2 cycles (ERR1, then ERR2).
- Address presented during ERR1: ignored, because HREADY = 0.
- Address presented during ERR2: sampled normally, whether the master cancels to IDLE or continues.
- Asserting reset mid-transfer forces IDLE/DEF immediately (asynchronous); the in-flight slave response is discarded.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE 2'b00, BUSY 01, NONSEQ 10, SEQ 11.
  - HRESP encodings: OKAY 2'b00, ERROR 2'b01.
  - The NS maximum of 4.
  - The default-slave state typedef.
- Sub-module ahb_default_slave, instanced once: contains the 3-state FSM; inputs are a sel/HTRANS/HREADY qualifier, outputs are HREADYOUT and HRESP.

## Test plan
- Reset: HRESETn low with HADDR = 32'h2000_0010 -> HSEL_S1 = 1 and the others 0; HREADY = 1, HRESP = 00, HRDATA = 0 during and after reset.
- Mapped read with wait:
  - Stimulus: NONSEQ read to 32'h0000_0004; S0 holds HREADYOUT_S0 = 0 for 2 cycles, then returns 32'hDEAD_BEEF.
  - Required: HREADY low for those 2 cycles, then HRDATA = 32'hDEAD_BEEF; dsel stays S0 throughout.
- Pipelined switch: a write to S0 followed in the next cycle by a read to S2 (32'h4000_0000) -> the data phase muxes S0 then S2 on consecutive cycles with no bubble.
- Unmapped access:
  - Stimulus: NONSEQ to 32'hF000_0000.
  - Required: ERR1 (HREADY = 0, HRESP = 01), then ERR2 (HREADY = 1, HRESP = 01), then IDLE OKAY.
  - Repeat with HTRANS = IDLE to the same address: 0-wait OKAY.
- Back-to-back errors: two NONSEQ transfers to 32'hF000_0000, the second issued in ERR2 -> ERR1, ERR2, ERR1, ERR2 with no IDLE between.
- Overlap and NS:
  - S0_MASK = 32'h0000_0000 makes S0 match everything -> S0 wins for all addresses.
  - With NS = 2, an access to 32'h6000_0000 routes to the default slave and returns ERROR.
  - Asserting reset during ERR1 -> HREADY = 1 and HRESP = 00 immediately.
